mdio_master: RTL
================

MDIO_MASTER -- requirements
Module: mdio_master

Interface
REQ-001 SHALL have parameter MDC_DIV, default 2: clk cycles per MDC half-period; legal range is MDC_DIV >= 1.
REQ-002 SHALL have parameter PRE_LEN, default 32: number of preamble '1' bits per frame; legal range is 0..32.
REQ-003 clk  input  1  system clock; all logic is on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 cmd_valid  input  1  command request.
REQ-006 cmd_ready  output  1  high when the block can accept a command.
REQ-007 cmd_op  input  2  OP field, sent verbatim; cmd_op[1]=1 is a read-type frame, cmd_op[1]=0 is a write-type frame.
REQ-008 cmd_c45  input  1  selects a Clause 45 frame (ST=00); the port is always present.
REQ-009 cmd_phy  input  5  PHYAD (Clause 22) or PRTAD (Clause 45).
REQ-010 cmd_reg  input  5  REGAD (Clause 22) or DEVAD (Clause 45).
REQ-011 cmd_wdata  input  16  write data or Clause 45 address.
REQ-012 rd_data  output  16  last data word read.
REQ-013 data_rdy  output  1  one-cycle pulse at the end of each frame.
REQ-014 rd_err  output  1  turnaround error flag for the last read, valid with data_rdy.
REQ-015 busy  output  1  a frame is in progress.
REQ-016 mdc  output  1  MDIO management clock.
REQ-017 mdio_oe  output  1  MDIO output enable.
REQ-018 mdio_out  output  1  MDIO driven value.
REQ-019 mdio_in  input  1  MDIO pad input.

Function
REQ-020 Handshake: cmd_ready SHALL equal (state==IDLE); a command is accepted on a clk edge where cmd_valid && cmd_ready, and all cmd_* fields are latched on that edge.
REQ-021 States SHALL be IDLE -> PRE -> HDR -> TA -> DATA -> DONE -> IDLE; PRE is skipped when PRE_LEN=0.
REQ-022 Bit cell: each frame bit SHALL last one MDC period, with mdc low for MDC_DIV cycles and then high for MDC_DIV cycles.
REQ-023 MDC: mdc SHALL be 0 whenever the block is not busy.
REQ-024 Drive timing: mdio_out and mdio_oe SHALL update only on the edge that starts a bit cell, i.e. at the mdc high->low transition or on the first cell after accept.
REQ-025 Sample timing: mdio_in SHALL be registered on the edge where mdc goes 0->1.
REQ-026 Frame content: PRE_LEN ones, then ST (01 for Clause 22, 00 for Clause 45), OP, PHY[4:0], REG[4:0], TA, 16 data bits; all fields are sent MSB first.
REQ-027 Write-type frames: mdio_oe SHALL be 1 for the entire frame, TA SHALL be driven as "10", and DATA SHALL drive cmd_wdata.
REQ-028 Read-type frames: mdio_oe SHALL be 0 from the first TA cell through the end of DATA, and DATA bits SHALL be shifted into a register MSB first.
REQ-029 rd_err SHALL be set when the second TA sample of a read frame is not 0.
REQ-030 Latency: with accept at edge T, DONE SHALL occur at edge T + (PRE_LEN+32)*2*MDC_DIV, and data_rdy SHALL be 1 for exactly that cycle.
REQ-031 In DONE: rd_data and rd_err SHALL update for read frames only; for write frames rd_data holds and rd_err is 0.
REQ-032 busy SHALL be 1 from the edge after accept through the DONE cycle inclusive, and mdio_oe SHALL be 0 in DONE and IDLE.
REQ-033 Boundary: cmd_valid while busy SHALL be ignored and nothing is queued; back-to-back commands are accepted in the IDLE cycle directly after DONE.
REQ-034 Boundary: reset asserted mid-frame SHALL abort the frame with no data_rdy pulse, and reset SHALL take priority over a simultaneous cmd_valid.
REQ-035 Counters: the bit counter SHALL be 6 bits and the divider counter SHALL be sized to $clog2(MDC_DIV)+1; neither counter wraps within a frame.

Reset
REQ-036 On reset the block SHALL enter state IDLE with mdc=0, mdio_oe=0, mdio_out=1, rd_data=16'h0000, rd_err=0, data_rdy=0 and busy=0; cmd_ready=1 from the first cycle after reset deasserts.

Configuration
REQ-037 With macro MDIO_CL45_EN defined, cmd_c45=1 SHALL produce ST=00 frames with OP sent verbatim (00 address, 01 write, 11 read, 10 post-read-increment).
REQ-038 Without MDIO_CL45_EN, cmd_c45 SHALL be ignored and ST SHALL always be 01 (Clause 22 only).

Verification
REQ-039 MDC_DIV=2, PRE_LEN=32, Clause 22 write of op=01, phy=5'h03, reg=5'h04, wdata=16'hA5C3 -> serial stream is 32 ones, then 01 01 00011 00100 10 1010010111000011; oe=1 throughout; data_rdy pulses 256 cycles after accept.
REQ-040 Clause 22 read of op=10 where the PHY model drives TA=z0 and data 16'h1234 -> oe falls at the TA cell, rd_data=16'h1234, rd_err=0.
REQ-041 Read where the model leaves the second TA bit at 1 -> rd_err=1 with data_rdy.
REQ-042 cmd_valid held high through a frame -> exactly one accept per frame, the second accept lands on the cycle after data_rdy, and mdc stays 0 between frames.
REQ-043 reset asserted at bit 20 of a frame -> the next cycle shows state IDLE with all outputs at reset values, and no data_rdy pulse occurs.
REQ-044 With MDIO_CL45_EN, cmd_c45=1, op=00, wdata=16'h0010 -> ST=00 on the wire; with PRE_LEN=0 and MDC_DIV=1, data_rdy pulses 64 cycles after accept.

Source files
------------

// File: rtl/mdio_master.sv
// MDIO management frame master (preamble, header, turnaround, 16 data bits).
// Define MDIO_CL45_EN to allow Clause 45 (ST=00) frames through cmd_c45.
module mdio_master #(
  parameter int MDC_DIV = 2,
  parameter int PRE_LEN = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic        cmd_c45,
  input  logic [4:0]  cmd_phy,
  input  logic [4:0]  cmd_reg,
  input  logic [15:0] cmd_wdata,
  output logic [15:0] rd_data,
  output logic        data_rdy,
  output logic        rd_err,
  output logic        busy,
  output logic        mdc,
  output logic        mdio_oe,
  output logic        mdio_out,
  input  logic        mdio_in
);

  typedef enum logic [2:0] {IDLE, PRE, HDR, TA, DATA, DONE} state_t;

  localparam int DW = $clog2(MDC_DIV) + 1;
  localparam logic [DW-1:0] DIV_LO  = DW'(MDC_DIV - 1);
  localparam logic [DW-1:0] DIV_END = DW'(2 * MDC_DIV - 1);
  localparam logic [5:0] BIT_LAST = 6'(PRE_LEN + 31);
  localparam logic [5:0] BIT_TA2  = 6'(PRE_LEN + 15);

  state_t        state_q, state_d;
  logic [DW-1:0] div_q, div_d;
  logic [5:0]    bit_q, bit_d;
  logic [31:0]   frm_q, frm_d;
  logic          rd_q, rd_d;
  logic [15:0]   sh_q, sh_d;
  logic          ta_err_q, ta_err_d;
  logic [15:0]   rd_data_q, rd_data_d;
  logic          rd_err_q, rd_err_d;
  logic          mdc_q, mdc_d;
  logic          oe_q, oe_d;
  logic          out_q, out_d;
  logic [1:0]    st;
  logic [31:0]   frm_new;

`ifdef MDIO_CL45_EN
  assign st = cmd_c45 ? 2'b00 : 2'b01;
`else
  logic unused_c45;
  assign unused_c45 = cmd_c45;
  assign st = 2'b01;
`endif

  assign frm_new = {st, cmd_op, cmd_phy, cmd_reg, 2'b10, cmd_wdata};

  // Frame position -> phase; b counts cells from the first preamble bit.
  function automatic state_t cell_state(input logic [5:0] b);
    int i;
    i = int'(b);
    if (i < PRE_LEN) return PRE;
    if (i < PRE_LEN + 14) return HDR;
    if (i < PRE_LEN + 16) return TA;
    return DATA;
  endfunction

  function automatic logic cell_bit(input logic [5:0] b,
                                    input logic [31:0] f);
    int i;
    i = int'(b);
    if (i < PRE_LEN) return 1'b1;
    return f[5'(31 - i + PRE_LEN)];
  endfunction

  function automatic logic cell_oe(input logic [5:0] b,
                                   input logic rd);
    state_t s;
    s = cell_state(b);
    return !(rd && (s == TA || s == DATA));
  endfunction

  always_comb begin
    state_d   = state_q;
    div_d     = div_q;
    bit_d     = bit_q;
    frm_d     = frm_q;
    rd_d      = rd_q;
    sh_d      = sh_q;
    ta_err_d  = ta_err_q;
    rd_data_d = rd_data_q;
    rd_err_d  = rd_err_q;
    oe_d      = oe_q;
    out_d     = out_q;
    unique case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          frm_d   = frm_new;
          rd_d    = cmd_op[1];
          div_d   = '0;
          bit_d   = '0;
          state_d = cell_state(6'd0);
          oe_d    = 1'b1;
          out_d   = cell_bit(6'd0, frm_new);
        end
      end
      DONE: state_d = IDLE;
      default: begin
        div_d = div_q + 1'b1;
        if (div_q == DIV_LO) begin
          if (state_q == DATA) sh_d = {sh_q[14:0], mdio_in};
          if (bit_q == BIT_TA2) ta_err_d = mdio_in;
        end
        if (div_q == DIV_END) begin
          div_d = '0;
          if (bit_q == BIT_LAST) begin
            state_d = DONE;
            oe_d    = 1'b0;
            out_d   = 1'b1;
            if (rd_q) begin
              rd_data_d = sh_q;
              rd_err_d  = ta_err_q;
            end else begin
              rd_err_d  = 1'b0;
            end
          end else begin
            bit_d   = bit_q + 1'b1;
            state_d = cell_state(bit_d);
            oe_d    = cell_oe(bit_d, rd_q);
            out_d   = cell_bit(bit_d, frm_q);
          end
        end
      end
    endcase
    mdc_d = (state_d != IDLE) && (state_d != DONE) && (div_d > DIV_LO);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      div_q     <= '0;
      bit_q     <= '0;
      frm_q     <= '0;
      rd_q      <= 1'b0;
      sh_q      <= '0;
      ta_err_q  <= 1'b0;
      rd_data_q <= '0;
      rd_err_q  <= 1'b0;
      mdc_q     <= 1'b0;
      oe_q      <= 1'b0;
      out_q     <= 1'b1;
    end else begin
      state_q   <= state_d;
      div_q     <= div_d;
      bit_q     <= bit_d;
      frm_q     <= frm_d;
      rd_q      <= rd_d;
      sh_q      <= sh_d;
      ta_err_q  <= ta_err_d;
      rd_data_q <= rd_data_d;
      rd_err_q  <= rd_err_d;
      mdc_q     <= mdc_d;
      oe_q      <= oe_d;
      out_q     <= out_d;
    end
  end

  assign cmd_ready = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign data_rdy  = (state_q == DONE);
  assign rd_data   = rd_data_q;
  assign rd_err    = rd_err_q;
  assign mdc       = mdc_q;
  assign mdio_oe   = oe_q;
  assign mdio_out  = out_q;

endmodule
